// File: rtl/dmem_resp.sv
// Word-organised data memory for the execution unit's load/store port: combinational read,
// clocked full-word write, address-window decode. Define DMEM_CLEAR_EN to add the post-reset clear sequencer.
module dmem_resp #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        hold_o,
  output logic        err_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;

  logic [31:0]   mem_q [DEPTH];
  logic [32:0]   offset;
  logic          hit;
  logic [AW-1:0] idx;
  logic          ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          err_q, err_d;
  logic          unused_offset_bits;

  // A 33-bit difference wraps above 2^32 when the address is below the base, so one compare covers both bounds.
  assign offset = {1'b0, mem_addr_i} - BASE_EXT;
  assign hit    = (offset < WIN_BYTES);
  assign idx    = offset[AW+1:2];
  assign unused_offset_bits = ^{offset[32:AW+2], offset[1:0]};

`ifdef DMEM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  assign ready  = (state_q == ST_READY);
  assign hold_o = (state_q == ST_CLEAR);
`else
  assign ready  = 1'b1;
  assign hold_o = 1'b0;
`endif

  // The clear sequencer owns the write port while it runs; core writes in that window are dropped.
  always_comb begin
    mem_we    = ready && mem_wr_en_i && hit;
    mem_waddr = idx;
    mem_wdata = mem_wr_data_i;
`ifdef DMEM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end
`endif
  end

  // NOTE: the array has no reset so it maps onto RAM macros; zeroing is the clear sequencer's job.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    err_d = err_q | (ready && mem_wr_en_i && !hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o         = err_q;
  assign mem_rd_data_o = (ready && hit) ? mem_q[idx] : 32'h0;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed scoreboard bench for dmem_resp: one instance at base 0, one at base 0x1000_0000, both DEPTH=16.
module tb_dmem_resp;

`ifdef DMEM_CLEAR_EN
  localparam int CLR_EDGES = 16;
`else
  localparam int CLR_EDGES = 0;
`endif

  typedef struct {
    string       tag;
    bit          hi;
    logic [31:0] exp;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lo_we = 1'b0, hi_we = 1'b0;
  logic [31:0] lo_addr = '0, hi_addr = 32'h1000_0000;
  logic [31:0] lo_wdata = '0, hi_wdata = '0;
  logic [31:0] lo_rdata, hi_rdata;
  logic        lo_hold, hi_hold, lo_err, hi_err;

  rd_exp_t     sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(16), .BASE_ADDR(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .mem_wr_en_i(lo_we), .mem_addr_i(lo_addr), .mem_wr_data_i(lo_wdata),
    .mem_rd_data_o(lo_rdata), .hold_o(lo_hold), .err_o(lo_err)
  );

  dmem_resp #(.DEPTH(16), .BASE_ADDR(32'h1000_0000)) u_dut_hi (
    .clk(clk), .rst(rst), .mem_wr_en_i(hi_we), .mem_addr_i(hi_addr), .mem_wr_data_i(hi_wdata),
    .mem_rd_data_o(hi_rdata), .hold_o(hi_hold), .err_o(hi_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_lo(input logic we, input logic [31:0] a, input logic [31:0] d);
    lo_we = we; lo_addr = a; lo_wdata = d;
  endtask

  task automatic drive_hi(input logic we, input logic [31:0] a, input logic [31:0] d);
    hi_we = we; hi_addr = a; hi_wdata = d;
  endtask

  task automatic expect_rd(input string tag, input bit hi, input logic [31:0] exp);
    rd_exp_t e;
    e.tag = tag; e.hi = hi; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sample_rd();
    rd_exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL sb_empty: observed no pending entry expected one");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, e.hi ? hi_rdata : lo_rdata, e.exp);
    end
  endtask

  task automatic read_lo(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_lo(1'b0, a, 32'h0);
    expect_rd(tag, 1'b0, exp);
    sample_rd();
  endtask

  task automatic read_hi(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive_hi(1'b0, a, 32'h0);
    expect_rd(tag, 1'b1, exp);
    sample_rd();
  endtask

  task automatic wait_hold_low(input string tag, input int start, input int exp_edges);
    int cnt = start;
    while ((lo_hold || hi_hold) && cnt < 200) begin
      tick();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_edges));
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_hold", {31'b0, lo_hold}, (CLR_EDGES > 0) ? 32'd1 : 32'd0);
    check("rst_err", {31'b0, lo_err}, 32'd0);
`ifdef DMEM_CLEAR_EN
    read_lo("rd_during_clear", 32'h3C, 32'h0);
    rst = 1'b0;
    repeat (7) tick();
    check("hold_mid_clear", {31'b0, lo_hold}, 32'd1);
    rst = 1'b1;
    #1;
    check("hold_in_rst", {31'b0, lo_hold}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    drive_lo(1'b1, 32'h0, 32'hFFFF_FFFF);
    tick();
    drive_lo(1'b0, 32'h0, 32'h0);
    wait_hold_low("clear_edges", 3, CLR_EDGES);
    check("err_after_clear_wr", {31'b0, lo_err}, 32'd0);
    read_lo("word0_cleared", 32'h00, 32'h0);
    read_lo("word15_cleared", 32'h3C, 32'h0);
`else
    rst = 1'b0;
    wait_hold_low("clear_edges", 0, CLR_EDGES);
    drive_lo(1'b1, 32'h00, 32'h0);
    tick();
    drive_lo(1'b1, 32'h08, 32'h0);
    tick();
    drive_lo(1'b1, 32'h3C, 32'h0);
    tick();
    drive_lo(1'b0, 32'h0, 32'h0);
    read_lo("word0_preload", 32'h00, 32'h0);
`endif

    // Basic write/read with read-before-write in the write cycle.
    drive_lo(1'b1, 32'h08, 32'hDEAD_BEEF);
    expect_rd("wr_same_cycle_old", 1'b0, 32'h0);
    sample_rd();
    tick();
    read_lo("wr_visible", 32'h08, 32'hDEAD_BEEF);
    read_lo("byte_offset_ignored", 32'h0B, 32'hDEAD_BEEF);

    // Back-to-back writes to the same word: last one wins.
    drive_lo(1'b1, 32'h08, 32'hAAAA_0001);
    tick();
    drive_lo(1'b1, 32'h08, 32'hBBBB_0002);
    expect_rd("b2b_old", 1'b0, 32'hAAAA_0001);
    sample_rd();
    tick();
    read_lo("b2b_last_wins", 32'h08, 32'hBBBB_0002);

    // Last word of the window.
    drive_lo(1'b1, 32'h3C, 32'hCAFE_F00D);
    tick();
    read_lo("last_word", 32'h3F, 32'hCAFE_F00D);

    // Out-of-range write: dropped (no alias onto word 0) and sticky error.
    drive_lo(1'b1, 32'h40, 32'h0000_1234);
    expect_rd("oor_rd_same", 1'b0, 32'h0);
    sample_rd();
    check("err_before_oor", {31'b0, lo_err}, 32'd0);
    tick();
    drive_lo(1'b0, 32'h40, 32'h0);
    check("err_set_oor", {31'b0, lo_err}, 32'd1);
    read_lo("oor_rd", 32'h40, 32'h0);
    read_lo("no_alias_word0", 32'h00, 32'h0);
    tick();
    tick();
    check("err_sticky", {31'b0, lo_err}, 32'd1);

    // High-base window edges.
    drive_hi(1'b1, 32'h1000_003C, 32'h5A5A_5A5A);
    tick();
    read_hi("hi_last_word", 32'h1000_003C, 32'h5A5A_5A5A);
    check("hi_err_in_range", {31'b0, hi_err}, 32'd0);
    drive_hi(1'b1, 32'h0FFF_FFFC, 32'h0000_0077);
    tick();
    drive_hi(1'b0, 32'h1000_0000, 32'h0);
    check("hi_err_below", {31'b0, hi_err}, 32'd1);
    read_hi("hi_below_rd", 32'h0FFF_FFFC, 32'h0);

    // Only reset clears the error flag.
    rst = 1'b1;
    #1;
    check("lo_err_rst", {31'b0, lo_err}, 32'd0);
    check("hi_err_rst", {31'b0, hi_err}, 32'd0);
    tick();
    rst = 1'b0;
    wait_hold_low("clear_edges_rst2", 0, CLR_EDGES);
    drive_hi(1'b1, 32'h1000_0040, 32'h0000_0099);
    tick();
    drive_hi(1'b0, 32'h1000_0000, 32'h0);
    check("hi_err_above", {31'b0, hi_err}, 32'd1);
    read_hi("hi_above_rd", 32'h1000_0040, 32'h0);
    check("lo_err_stays_clear", {31'b0, lo_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
